// File: rtl/adder_result_checker.sv
// Response checker for adder blocks: compares each accepted {cout,sum} against a+b,
// counts matches/mismatches, latches the first failing vector and reports a verdict.
module adder_result_checker #(
    parameter int WIDTH       = 1,
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_sum,
    output logic             first_fail_cout,
    output logic [1:0]       dbg_state
);

    // Handshake: a vector transfers on any rising edge where in_valid && in_ready;
    // in_valid while in_ready is low is dropped without side effects.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_NUM  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LP_MAX  = {CNT_W{1'b1}};

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_cap_valid;
    logic [CNT_W-1:0] r_cap_idx;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [WIDTH-1:0] r_cap_sum;
    logic             r_cap_cout;

    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_fail_seen;
    logic [CNT_W-1:0] r_ff_idx;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [WIDTH-1:0] r_ff_sum;
    logic             r_ff_cout;

    logic             w_start_run;
    logic             w_accept;
    logic             w_last_cmp;
    logic [WIDTH:0]   w_expected;
    logic             w_match;

    assign w_accept   = in_valid && in_ready;
    assign w_last_cmp = r_cap_valid && (r_cap_idx == LP_LAST);
    assign w_expected = {1'b0, r_cap_a} + {1'b0, r_cap_b};
    assign w_match    = ({r_cap_cout, r_cap_sum} == w_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next      = S_CHECK;
                    w_start_run = 1'b1;
                end
            end
            S_CHECK: begin
                busy     = 1'b1;
                in_ready = (r_acc_cnt < LP_NUM);
                // Leave on the same edge that retires the last vector's compare.
                if (w_last_cmp) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next      = S_CHECK;
                    w_start_run = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt   <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_cap_sum   <= '0;
            r_cap_cout  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_sum    <= '0;
            r_ff_cout   <= 1'b0;
        end else if (w_start_run) begin
            r_acc_cnt   <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_cap_sum   <= '0;
            r_cap_cout  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_sum    <= '0;
            r_ff_cout   <= 1'b0;
        end else begin
            r_cap_valid <= w_accept;
            if (w_accept) begin
                r_cap_idx  <= r_acc_cnt;
                r_cap_a    <= a;
                r_cap_b    <= b;
                r_cap_sum  <= sum;
                r_cap_cout <= cout;
                r_acc_cnt  <= r_acc_cnt + LP_ONE;
            end
            if (r_cap_valid) begin
                if (w_match) begin
                    if (r_pass_cnt != LP_MAX) begin
                        r_pass_cnt <= r_pass_cnt + LP_ONE;
                    end
                end else begin
                    if (r_fail_cnt != LP_MAX) begin
                        r_fail_cnt <= r_fail_cnt + LP_ONE;
                    end
                    if (!r_fail_seen) begin
                        r_fail_seen <= 1'b1;
                        r_ff_idx    <= r_cap_idx;
                        r_ff_a      <= r_cap_a;
                        r_ff_b      <= r_cap_b;
                        r_ff_sum    <= r_cap_sum;
                        r_ff_cout   <= r_cap_cout;
                    end
                end
            end
        end
    end

    assign pass            = done && (r_fail_cnt == '0);
    assign pass_cnt        = r_pass_cnt;
    assign fail_cnt        = r_fail_cnt;
    assign first_fail_idx  = r_ff_idx;
    assign first_fail_a    = r_ff_a;
    assign first_fail_b    = r_ff_b;
    assign first_fail_sum  = r_ff_sum;
    assign first_fail_cout = r_ff_cout;
    assign dbg_state       = r_state;

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Sequential response checker for the adder blocks (half adder, WIDTH=1, and wider ripple adders). It samples operand/result vectors driven at the adder under test, compares each against a+b, and counts passes and failures. It latches the first failing vector and reports a pass/fail verdict after a programmed number of vectors. It sits on the output side of the adder and complements the stimulus sequence that drives the operands, enabling on-board self-test.

## Interface
- WIDTH, 1: operand and sum width in bits
- NUM_VECTORS, 4: vectors checked per run (1..2^CNT_W-1)
- CNT_W, 8: width of vector index and pass/fail counters
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a run (one-cycle pulse)
- in_valid  input  1  a/b/sum/cout valid this cycle
- a  input  WIDTH  operand A applied to adder
- b  input  WIDTH  operand B applied to adder
- sum  input  WIDTH  adder sum output
- cout  input  1  adder carry output
- in_ready  output  1  checker accepts a vector this cycle
- busy  output  1  run in progress
- done  output  1  run complete, results stable
- pass  output  1  done and fail_cnt==0
- pass_cnt  output  CNT_W  matching vectors (saturating)
- fail_cnt  output  CNT_W  mismatching vectors (saturating)
- first_fail_idx  output  CNT_W  index (0-based) of first mismatch
- first_fail_a, first_fail_b, first_fail_sum  output  WIDTH  captured first failing vector
- first_fail_cout  output  1  captured first failing carry

## Operation
- States: IDLE, CHECK, DONE.
- IDLE: busy=0, done=0, in_ready=0. start -> CHECK; clears counters, accept index, first-fail registers, fail_seen flag.
- CHECK: busy=1. in_ready=1 while accepted count < NUM_VECTORS. Vector accepted when in_valid && in_ready; it is captured into a one-stage register with its index.
- Compare stage: expected = {1'b0,a}+{1'b0,b} in WIDTH+1 bits; match when {cout,sum}==expected.
- Match: pass_cnt+1. Mismatch: fail_cnt+1; if fail_seen==0, capture index/a/b/sum/cout and set fail_seen.
- Counters saturate at 2^CNT_W-1; no wrap.
- After the compare of vector NUM_VECTORS-1, state -> DONE on the same edge.
- DONE: done=1, busy=0, in_ready=0, outputs hold. start -> CHECK with full clear (new run).
- in_valid while in_ready=0 is ignored (not counted, not captured).
- start in CHECK is ignored.
- rst at any time: immediate return to IDLE, all outputs 0, run abandoned.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pass=0, all counters and first_fail_* = 0.
- start sampled at edge E -> busy=1, in_ready=1 in the cycle after E.
- Vector accepted at edge E0 -> compared in the following cycle -> counters/first-fail registers updated at E1, visible the cycle after E1 (latency 2 edges).
- Back-to-back acceptance allowed: one vector per cycle, no bubbles required.
- in_ready drops in the cycle after the NUM_VECTORS-th acceptance; done rises one cycle later, with final counts valid in that same cycle.
- pass is combinational from done and fail_cnt; never high outside DONE.
- Simultaneous start and rst: rst wins.

## Test plan
- Half-adder golden run (WIDTH=1, NUM_VECTORS=4): start, then vectors (a,b,sum,cout) = (0,0,0,0),(1,0,1,0),(0,1,1,0),(1,1,0,1) on consecutive cycles -> done after final compare, pass_cnt=4, fail_cnt=0, pass=1.
- Fault injection: same sequence with vector 1 sum=0 and vector 3 cout=0 -> fail_cnt=2, pass_cnt=2, pass=0, first_fail_idx=1, first_fail_a=1, first_fail_b=0, first_fail_sum=0, first_fail_cout=0.
- Gapped/extra valids (WIDTH=1): in_valid pulsed every third cycle, plus 2 extra valids after in_ready falls and valids in IDLE -> pass_cnt=4 exactly; extras ignored.
- Wide carry (WIDTH=4): a=15,b=1,sum=0,cout=1 -> match; a=15,b=1,sum=0,cout=0 -> mismatch; a=7,b=8,sum=15,cout=0 -> match.
- Saturation (CNT_W=2, NUM_VECTORS=3 failing then rerun with 3 passing): fail_cnt=3; restart from DONE clears to 0, pass_cnt=3; separate NUM_VECTORS=3 of 2 passes/1 fail -> pass_cnt=2, fail_cnt=1.
- Reset mid-run: assert rst after 2 of 4 vectors -> all outputs 0 in the same cycle as rst; new start with 4 golden vectors -> pass_cnt=4, pass=1.
